// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  // Opcodes recognised by the control unit and the immediate generator
  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_I      = 7'h13;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;

  // FSM states; the values are visible on state_o for debug
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEM_ADR = 4'd2,
    S_MEM_RD  = 4'd3,
    S_MEM_WB  = 4'd4,
    S_MEM_WR  = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_LUI     = 4'd12,
    S_TRAP    = 4'd15
  } state_t;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;
  localparam logic [3:0] ALU_SRA = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  // Operation class requested by the FSM from the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2,
    ALUOP_LUI   = 2'd3
  } alu_op_t;

  // Datapath mux selects
  localparam logic       ADR_PC        = 1'b0;
  localparam logic       ADR_ALUOUT    = 1'b1;
  localparam logic [1:0] SRCA_PC       = 2'b00;
  localparam logic [1:0] SRCA_OLDPC    = 2'b01;
  localparam logic [1:0] SRCA_REGA     = 2'b10;
  localparam logic [1:0] SRCB_REGB     = 2'b00;
  localparam logic [1:0] SRCB_IMM      = 2'b01;
  localparam logic [1:0] SRCB_FOUR     = 2'b10;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to an ALU operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output logic [3:0] o_alu_control
);

  // funct7b5 selects SUB only for R-type; it selects SRA for both R and I shifts
  always_comb begin
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_LUI: o_alu_control = ALU_LUI;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b111:  o_alu_control = ALU_AND;
          3'b110:  o_alu_control = ALU_OR;
          3'b100:  o_alu_control = ALU_XOR;
          3'b010:  o_alu_control = ALU_SLT;
          3'b001:  o_alu_control = ALU_SLL;
          3'b101:  o_alu_control = i_funct7b5 ? ALU_SRA : ALU_SRL;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the shared multicycle RV32I datapath through
// fetch/decode/execute/memory/writeback steps, with memory-ready stalls.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [3:0] alu_control_o,
  output logic [1:0] result_src_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     r_state;
  state_t     w_next;
  alu_op_t    w_alu_op;
  logic [3:0] w_alu_ctrl;
  logic       w_ir_write;
  logic       w_pc_write;
  logic       w_adr_src;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_reg_write;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_result_src;
  logic       w_illegal;

  // State register; reset returns to FETCH from anywhere, abandoning any access
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Next-state and per-state datapath controls
  always_comb begin
    w_next       = r_state;
    w_alu_op     = ALUOP_ADD;
    w_ir_write   = 1'b0;
    w_pc_write   = 1'b0;
    w_adr_src    = ADR_PC;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_src_a      = SRCA_PC;
    w_src_b      = SRCB_REGB;
    w_result_src = RES_ALUOUT;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read   = 1'b1;
        w_src_b      = SRCB_FOUR;
        w_result_src = RES_ALURESULT;
        w_ir_write   = mem_ready_i;
        w_pc_write   = mem_ready_i;
        if (mem_ready_i) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
        case (op_i)
          OP_LOAD, OP_STORE: w_next = (funct3_i == 3'b010) ? S_MEM_ADR : S_TRAP;
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_BRANCH:         w_next = (funct3_i[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        w_src_a = SRCA_REGA;
        w_src_b = SRCB_IMM;
        w_next  = (op_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        w_adr_src  = ADR_ALUOUT;
        w_mem_read = 1'b1;
        if (mem_ready_i) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_result_src = RES_MEMDATA;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WR: begin
        w_adr_src   = ADR_ALUOUT;
        w_mem_write = 1'b1;
        if (mem_ready_i) w_next = S_FETCH;
      end
      S_EXEC_R: begin
        w_src_a  = SRCA_REGA;
        w_src_b  = SRCB_REGB;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALU_WB;
      end
      S_EXEC_I: begin
        w_src_a  = SRCA_REGA;
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_FUNCT;
        w_next   = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a    = SRCA_REGA;
        w_src_b    = SRCB_REGB;
        w_alu_op   = ALUOP_SUB;
        w_pc_write = funct3_i[0] ? ~zero_i : zero_i;
        w_next     = S_FETCH;
      end
      S_JALR: begin
        w_src_a = SRCA_REGA;
        w_src_b = SRCB_IMM;
        w_next  = S_JAL;
      end
      S_JAL: begin
        w_pc_write = 1'b1;
        w_src_a    = SRCA_OLDPC;
        w_src_b    = SRCB_FOUR;
        w_next     = S_ALU_WB;
      end
      S_LUI: begin
        w_src_b  = SRCB_IMM;
        w_alu_op = ALUOP_LUI;
        w_next   = S_ALU_WB;
      end
      S_TRAP: begin
        w_illegal = 1'b1;
        w_next    = S_TRAP;
      end
      default: w_next = S_TRAP;
    endcase
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (funct3_i),
    .i_funct7b5    (funct7b5_i),
    .i_is_rtype    (r_state == S_EXEC_R),
    .o_alu_control (w_alu_ctrl)
  );

  // Output stage: reset forces every control quiet so no write fires during reset
  always_comb begin
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    adr_src_o     = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    reg_write_o   = 1'b0;
    alu_src_a_o   = '0;
    alu_src_b_o   = '0;
    alu_control_o = '0;
    result_src_o  = '0;
    illegal_o     = 1'b0;
    state_o       = '0;
    if (!reset) begin
      ir_write_o    = w_ir_write;
      pc_write_o    = w_pc_write;
      adr_src_o     = w_adr_src;
      mem_read_o    = w_mem_read;
      mem_write_o   = w_mem_write;
      reg_write_o   = w_reg_write;
      alu_src_a_o   = w_src_a;
      alu_src_b_o   = w_src_b;
      alu_control_o = w_alu_ctrl;
      result_src_o  = w_result_src;
      illegal_o     = w_illegal;
      state_o       = r_state;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: each cycle's expected control
// vector is queued as stimulus is applied and compared when outputs settle.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       ir_write_o;
  logic       pc_write_o;
  logic       adr_src_o;
  logic       mem_read_o;
  logic       mem_write_o;
  logic       reg_write_o;
  logic [1:0] alu_src_a_o;
  logic [1:0] alu_src_b_o;
  logic [3:0] alu_control_o;
  logic [1:0] result_src_o;
  logic       illegal_o;
  logic [3:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [20:0] sb[$];

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk           (clk),
    .reset         (reset),
    .op_i          (op_i),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .ir_write_o    (ir_write_o),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .mem_read_o    (mem_read_o),
    .mem_write_o   (mem_write_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_control_o (alu_control_o),
    .result_src_o  (result_src_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  // Vector layout: state, ir_write, pc_write, adr_src, mem_read, mem_write,
  // reg_write, src_a, src_b, alu_control, result_src, illegal
  function automatic logic [20:0] mk(input logic [3:0] st, input logic irw, input logic pcw,
                                     input logic adr, input logic mrd, input logic mwr,
                                     input logic rw, input logic [1:0] a, input logic [1:0] b,
                                     input logic [3:0] alu, input logic [1:0] res, input logic ill);
    return {st, irw, pcw, adr, mrd, mwr, rw, a, b, alu, res, ill};
  endfunction

  function automatic logic [20:0] e_fetch(input logic rdy);
    return mk(4'd0, rdy, rdy, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b10, 4'd0, 2'b10, 1'b0);
  endfunction
  function automatic logic [20:0] e_decode();
    return mk(4'd1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memadr();
    return mk(4'd2, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memrd();
    return mk(4'd3, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_memwb();
    return mk(4'd4, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 2'b01, 0);
  endfunction
  function automatic logic [20:0] e_memwr();
    return mk(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_execr(input logic [3:0] alu);
    return mk(4'd6, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_execi(input logic [3:0] alu);
    return mk(4'd7, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_aluwb();
    return mk(4'd8, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_branch(input logic pcw);
    return mk(4'd9, 0, pcw, 0, 0, 0, 0, 2'b10, 2'b00, 4'd1, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_jal();
    return mk(4'd10, 0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_jalr();
    return mk(4'd11, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 4'd0, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_lui();
    return mk(4'd12, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 4'd9, 2'b00, 0);
  endfunction
  function automatic logic [20:0] e_trap();
    return mk(4'd15, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, 1);
  endfunction

  task automatic ins(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_i = op;
    funct3_i = f3;
    funct7b5_i = f7;
  endtask

  // Inputs for the current cycle are already driven; queue the expectation,
  // compare once outputs settle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [20:0] e);
    logic [20:0] got;
    logic [20:0] want;
    sb.push_back(e);
    #2;
    got = {state_o, ir_write_o, pc_write_o, adr_src_o, mem_read_o, mem_write_o, reg_write_o,
           alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o, illegal_o};
    want = sb.pop_front();
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, want);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_ready_i = 1'b1;
    zero_i = 1'b0;
    ins(7'h33, 3'b000, 1'b0);
    @(posedge clk);
    #1;
    step("reset0", '0);
    step("reset1", '0);
    reset = 1'b0;

    // R-type ADD, then SUB
    step("add_fetch", e_fetch(1'b1));
    step("add_decode", e_decode());
    step("add_exec", e_execr(4'd0));
    step("add_wb", e_aluwb());
    ins(7'h33, 3'b000, 1'b1);
    step("sub_fetch", e_fetch(1'b1));
    step("sub_decode", e_decode());
    step("sub_exec", e_execr(4'd1));
    step("sub_wb", e_aluwb());

    // LW with a fetch wait and two MEM_RD wait states
    ins(7'h03, 3'b010, 1'b0);
    mem_ready_i = 1'b0;
    step("lw_fetch_wait", e_fetch(1'b0));
    mem_ready_i = 1'b1;
    step("lw_fetch", e_fetch(1'b1));
    step("lw_decode", e_decode());
    step("lw_adr", e_memadr());
    mem_ready_i = 1'b0;
    step("lw_rd_wait0", e_memrd());
    step("lw_rd_wait1", e_memrd());
    mem_ready_i = 1'b1;
    step("lw_rd_done", e_memrd());
    step("lw_wb", e_memwb());

    // Branches
    zero_i = 1'b1;
    ins(7'h63, 3'b000, 1'b0);
    step("beq_fetch", e_fetch(1'b1));
    step("beq_decode", e_decode());
    step("beq_taken", e_branch(1'b1));
    ins(7'h63, 3'b001, 1'b0);
    step("bne_fetch", e_fetch(1'b1));
    step("bne_decode", e_decode());
    step("bne_not_taken", e_branch(1'b0));
    zero_i = 1'b0;
    step("bne2_fetch", e_fetch(1'b1));
    step("bne2_decode", e_decode());
    step("bne2_taken", e_branch(1'b1));

    // JALR
    ins(7'h67, 3'b000, 1'b0);
    step("jalr_fetch", e_fetch(1'b1));
    step("jalr_decode", e_decode());
    step("jalr_tgt", e_jalr());
    step("jalr_jal", e_jal());
    step("jalr_wb", e_aluwb());

    // SRAI, and ADDI with bit 30 set must remain ADD
    ins(7'h13, 3'b101, 1'b1);
    step("srai_fetch", e_fetch(1'b1));
    step("srai_decode", e_decode());
    step("srai_exec", e_execi(4'd8));
    step("srai_wb", e_aluwb());
    ins(7'h13, 3'b000, 1'b1);
    step("addi_fetch", e_fetch(1'b1));
    step("addi_decode", e_decode());
    step("addi_exec", e_execi(4'd0));
    step("addi_wb", e_aluwb());

    // LUI
    ins(7'h37, 3'b000, 1'b0);
    step("lui_fetch", e_fetch(1'b1));
    step("lui_decode", e_decode());
    step("lui_exec", e_lui());
    step("lui_wb", e_aluwb());

    // Illegal opcode traps until reset
    ins(7'h7F, 3'b000, 1'b0);
    step("ill_fetch", e_fetch(1'b1));
    step("ill_decode", e_decode());
    for (int i = 0; i < 10; i++) step("ill_trap", e_trap());
    reset = 1'b1;
    step("trap_reset", '0);
    reset = 1'b0;

    // LW with a non-word funct3 is illegal
    ins(7'h03, 3'b000, 1'b0);
    step("lb_fetch", e_fetch(1'b1));
    step("lb_decode", e_decode());
    step("lb_trap", e_trap());
    reset = 1'b1;
    step("lb_reset", '0);
    reset = 1'b0;

    // Store stalled in MEM_WR, then reset mid-access
    ins(7'h23, 3'b010, 1'b0);
    step("sw_fetch", e_fetch(1'b1));
    step("sw_decode", e_decode());
    step("sw_adr", e_memadr());
    mem_ready_i = 1'b0;
    step("sw_wr_wait", e_memwr());
    reset = 1'b1;
    step("sw_reset", '0);
    reset = 1'b0;
    mem_ready_i = 1'b1;
    step("sw_after_reset", e_fetch(1'b1));

    // Full store with zero-wait memory
    step("sw2_decode", e_decode());
    step("sw2_adr", e_memadr());
    step("sw2_wr", e_memwr());
    step("sw2_next_fetch", e_fetch(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style finite state machine that sequences the shared multicycle RV32I datapath: PC register, instruction register, unified instruction/data memory port, register file, the immediate generator and a single ALU. Each instruction is split into FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK steps. The block drives the write enables and mux selects for every step, and stalls on a memory-ready handshake. It decodes the same opcode set the immediate generator recognises and flags anything else as illegal.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- op_i  in  7  instruction[6:0], taken from the instruction register.
- funct3_i  in  3  instruction[14:12].
- funct7b5_i  in  1  instruction[30].
- zero_i  in  1  ALU zero flag.
- mem_ready_i  in  1  memory completes the current access this cycle.
- ir_write_o  out  1  loads the instruction register.
- pc_write_o  out  1  loads the PC from the result mux.
- adr_src_o  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read_o  out  1  read strobe.
- mem_write_o  out  1  write strobe.
- reg_write_o  out  1  register file write.
- alu_src_a_o  out  2  ALU A select: 00=PC, 01=oldPC, 10=regA.
- alu_src_b_o  out  2  ALU B select: 00=regB, 01=immediate, 10=constant 4.
- alu_control_o  out  4  ALU operation code.
- result_src_o  out  2  result mux select: 00=ALUOut, 01=memory data register, 10=ALU result.
- illegal_o  out  1  high while in TRAP.
- state_o  out  4  current state, for debug.

## Operation
- **Opcodes:** R 0x33, I-logic 0x13, load 0x03, store 0x23, branch 0x63, JAL 0x6F, JALR 0x67, LUI 0x37.
- **ALU codes:** ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5, SLL 6, SRL 7, SRA 8, LUI 9. LUI computes B<<12, because the immediate generator supplies the unshifted upper immediate.
- **State encoding:** FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC_R 6, EXEC_I 7, ALU_WB 8, BRANCH 9, JAL 10, JALR 11, LUI 12, TRAP 15.
- **FETCH:** adr_src=0, mem_read=1, A=PC, B=4, ADD, result_src=10. ir_write and pc_write are both driven by mem_ready_i. Stay in FETCH while !mem_ready_i; otherwise go to DECODE.
- **DECODE:** A=oldPC, B=imm, ADD, which latches the branch/JAL target into ALUOut. Next state by opcode:
  - load/store with funct3=010 → MEM_ADR
  - R → EXEC_R; I-logic → EXEC_I
  - branch with funct3 000/001 → BRANCH
  - JAL → JAL; JALR → JALR; LUI → LUI
  - anything else → TRAP
- **MEM_ADR:** A=regA, B=imm, ADD. Go to MEM_RD for a load, MEM_WR for a store.
- **MEM_RD:** adr_src=1, mem_read=1. Hold until mem_ready_i, then MEM_WB.
- **MEM_WB:** result_src=01, reg_write=1, then FETCH.
- **MEM_WR:** adr_src=1, mem_write=1. Hold until mem_ready_i, then FETCH.
- **EXEC_R:** A=regA, B=regB. ALU code from funct3/funct7b5:
  - 000: ADD, or SUB when funct7b5=1
  - 111: AND; 110: OR; 100: XOR; 010: SLT; 001: SLL
  - 101: SRL, or SRA when funct7b5=1
  - Then ALU_WB.
- **EXEC_I:** A=regA, B=imm. Same decode as EXEC_R, except funct7b5 is honoured only for funct3=101 (000 is always ADD). Then ALU_WB.
- **ALU_WB:** result_src=00, reg_write=1, then FETCH.
- **BRANCH:** A=regA, B=regB, SUB, result_src=00. pc_write = zero_i for BEQ, !zero_i for BNE. Then FETCH.
- **JALR:** A=regA, B=imm, ADD, so the target goes into ALUOut. Then JAL.
- **JAL:** result_src=00, pc_write=1, A=oldPC, B=4, ADD, so the link address goes into ALUOut. Then ALU_WB.
- **LUI:** B=imm, ALU code LUI. Then ALU_WB.
- **TRAP:** all enables 0, illegal_o=1. Stays in TRAP until reset.
- In every state, any enable or select not listed above is 0.

## Timing
- **Reset:** while reset=1, all enables and selects are 0, illegal_o=0 and state_o=0. The first clock after reset deasserts begins FETCH.
- **Reset mid-operation:** on the next edge the state becomes FETCH. Any pending memory access is abandoned, and no write enable is asserted in the cycle that reset is high.
- **Output timing:** outputs are combinational from the state register. The exceptions are:
  - FETCH ir_write/pc_write, which depend on mem_ready_i;
  - BRANCH pc_write, which depends on zero_i.
- **Cycle counts with zero-wait memory:**
  - R, I-logic, LUI, JAL, store: 4 cycles
  - load, JALR: 5 cycles
  - branch: 3 cycles
- **Wait states:** each cycle with mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds one cycle. The strobes stay asserted and their addresses stay stable throughout the wait.

## Structure
- Package `riscv_ctrl_pkg` holds the opcode constants, state encoding, ALU codes and mux-select encodings. The immediate generator shares the opcode constants from this package.
- One sub-module, `alu_decoder`: a combinational mapping from {alu_op class, funct3, funct7b5, is_rtype} to alu_control. The main FSM instantiates it.

## Test plan
- **R-type:** reset, then ADD (0x33, f3=000, f7b5=0) with mem_ready=1. Expect states 0→1→6→8→0; alu_control=0 in EXEC_R; reg_write=1 only in ALU_WB.
- **Load with wait states:** LW with mem_ready low for 2 cycles in MEM_RD. Expect mem_read and adr_src=1 held for 3 cycles, then MEM_WB with result_src=01; 7 cycles total.
- **Branches:**
  - BEQ with zero_i=1: pc_write=1 in BRANCH.
  - BNE with zero_i=1: pc_write=0.
  - Both take 3 cycles.
- **Jumps:**
  - JALR: states 1→11→10→8. pc_write in JAL with result_src=00; link written in ALU_WB.
  - SRAI (0x13, f3=101, f7b5=1): alu_control=8.
- **Illegal and reset:**
  - Opcode 0x7F: TRAP; illegal_o stays 1 for 10 cycles.
  - Reset pulse during MEM_WR: next state FETCH, mem_write=0.
